// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared types and constants for the reorder buffer slice:
//   ROB_DEPTH          - number of in-flight entries (8)
//   lc3b_word          - 16-bit datapath word
//   lc3b_ext_reg       - extended register index; REGISTER_PC means "no GPR write"
//   lc3b_rob_id        - 4-bit entry id; ids 0-7 are real, REORDER_ID_INVALID = 8
//   rob_ptr_t          - 3-bit circular head/tail pointer
//   lc3b_rob_entry     - per-entry bookkeeping record
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 8;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_ext_reg;
  typedef logic [3:0]  lc3b_rob_id;
  typedef logic [2:0]  rob_ptr_t;

  localparam lc3b_ext_reg REGISTER_PC        = 4'd8;
  localparam lc3b_rob_id  REORDER_ID_INVALID = 4'd8;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mispredict;
    lc3b_ext_reg dest;
    lc3b_word    value;
    lc3b_word    target;
  } lc3b_rob_entry;

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every non-clock/reset signal of the reorder buffer.
//   dispatch : alloc_req, alloc_dest, alloc_is_branch -> alloc_ready, alloc_id
//   CDB      : cdb_valid, cdb_id, cdb_value, cdb_mispredict, cdb_target
//   regfile  : rf_load_value/rf_value/rf_dest_value (value port),
//              rf_load_rob/rf_rob_in/rf_dest_rob (tag port), flush
//   PC       : pc_load, pc_target
//   status   : count (occupancy 0-8)
// slave  = the reorder buffer itself, master = the surrounding pipeline.
// -----------------------------------------------------------------------------
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic        alloc_req;
  lc3b_ext_reg alloc_dest;
  logic        alloc_is_branch;
  logic        alloc_ready;
  lc3b_rob_id  alloc_id;

  logic        cdb_valid;
  lc3b_rob_id  cdb_id;
  lc3b_word    cdb_value;
  logic        cdb_mispredict;
  lc3b_word    cdb_target;

  logic        rf_load_value;
  lc3b_word    rf_value;
  lc3b_ext_reg rf_dest_value;
  logic        rf_load_rob;
  lc3b_rob_id  rf_rob_in;
  lc3b_ext_reg rf_dest_rob;
  logic        flush;

  logic        pc_load;
  lc3b_word    pc_target;
  logic [3:0]  count;

  modport slave (
    input  alloc_req, alloc_dest, alloc_is_branch,
    input  cdb_valid, cdb_id, cdb_value, cdb_mispredict, cdb_target,
    output alloc_ready, alloc_id,
    output rf_load_value, rf_value, rf_dest_value,
    output rf_load_rob, rf_rob_in, rf_dest_rob, flush,
    output pc_load, pc_target, count
  );

  modport master (
    output alloc_req, alloc_dest, alloc_is_branch,
    output cdb_valid, cdb_id, cdb_value, cdb_mispredict, cdb_target,
    input  alloc_ready, alloc_id,
    input  rf_load_value, rf_value, rf_dest_value,
    input  rf_load_rob, rf_rob_in, rf_dest_rob, flush,
    input  pc_load, pc_target, count
  );

endinterface

// File: rtl/reorder_buffer_retag_search.sv
// -----------------------------------------------------------------------------
// rob_retag_search
// Combinational search for the youngest valid entry younger than the head
// whose destination equals match_dest.
//   en         in  enable (committing a GPR write)
//   head       in  current head pointer (oldest entry, excluded from search)
//   valid      in  per-entry valid bits
//   dest       in  per-entry destination registers
//   match_dest in  destination being committed
//   hit        out a younger matching entry exists
//   id         out id of the youngest match (REORDER_ID_INVALID when no hit)
// -----------------------------------------------------------------------------
module rob_retag_search
  import reorder_buffer_pkg::*;
(
  input  logic                 en,
  input  rob_ptr_t             head,
  input  logic [ROB_DEPTH-1:0] valid,
  input  lc3b_ext_reg          dest [ROB_DEPTH],
  input  lc3b_ext_reg          match_dest,
  output logic                 hit,
  output lc3b_rob_id           id
);

  rob_ptr_t idx;
  logic     match;

  // Walk from head+1 toward the tail; the last match seen is the youngest.
  // Valid entries are contiguous from head, so valid alone bounds the window.
  always_comb begin
    hit   = 1'b0;
    id    = REORDER_ID_INVALID;
    idx   = 3'd0;
    match = 1'b0;
    for (int k = 1; k < ROB_DEPTH; k++) begin
      idx   = head + rob_ptr_t'(k);
      match = en & valid[idx] & (dest[idx] == match_dest);
      hit   = hit | match;
      id    = match ? {1'b0, idx} : id;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// 8-entry in-order-retire reorder buffer for the LC-3b pipeline.
//   clk   in  rising-edge clock
//   reset in  synchronous active-high reset (drives flush while high)
//   bus   reorder_buffer_if.slave - dispatch, CDB, regfile, PC and status
// Entries are allocated at tail, completed out of order by the CDB, and
// retired one per cycle from head. A mispredicted branch retiring flushes
// everything. When a committed value write would clear a tag still owned by
// a younger entry, the tag port re-installs the youngest owner's tag.
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  reorder_buffer_if.slave bus
);

  lc3b_rob_entry entries_q [ROB_DEPTH];
  lc3b_rob_entry entries_d [ROB_DEPTH];
  rob_ptr_t      head_q, head_d;
  rob_ptr_t      tail_q, tail_d;
  logic [3:0]    count_q, count_d;

  lc3b_rob_entry        head_e;
  logic                 commit_s;
  logic                 mispredict_commit_s;
  logic                 flush_s;
  logic                 value_write_s;
  logic                 retag_en_s;
  logic                 retag_hit_s;
  lc3b_rob_id           retag_id_s;
  logic                 alloc_ready_s;
  logic                 alloc_fire_s;
  logic                 cdb_accept_s;
  logic [ROB_DEPTH-1:0] valid_vec_s;
  lc3b_ext_reg          dest_vec_s [ROB_DEPTH];

  // Commit / flush decode from the registered head entry.
  always_comb begin
    head_e              = entries_q[head_q];
    commit_s            = ~reset & head_e.valid & head_e.done;
    mispredict_commit_s = commit_s & head_e.mispredict;
    flush_s             = reset | mispredict_commit_s;
    value_write_s       = commit_s & (head_e.dest != REGISTER_PC);
    retag_en_s          = value_write_s & ~flush_s;
  end

  // Flatten the entry fields the retag search needs.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      valid_vec_s[i] = entries_q[i].valid;
      dest_vec_s[i]  = entries_q[i].dest;
    end
  end

  rob_retag_search u_retag (
    .en         (retag_en_s),
    .head       (head_q),
    .valid      (valid_vec_s),
    .dest       (dest_vec_s),
    .match_dest (head_e.dest),
    .hit        (retag_hit_s),
    .id         (retag_id_s)
  );

  // Dispatch acceptance and CDB qualification. Full uses the registered
  // count, so a same-cycle commit never frees a slot for dispatch.
  always_comb begin
    alloc_ready_s = ~flush_s & ~retag_hit_s & (count_q < 4'd8);
    alloc_fire_s  = bus.alloc_req & alloc_ready_s;
    cdb_accept_s  = bus.cdb_valid & ~flush_s & ~bus.cdb_id[3]
                  & entries_q[bus.cdb_id[2:0]].valid
                  & ~entries_q[bus.cdb_id[2:0]].done;
  end

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush_s) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i] = '0;
      end
      head_d  = 3'd0;
      tail_d  = 3'd0;
      count_d = 4'd0;
    end else begin
      if (cdb_accept_s) begin
        entries_d[bus.cdb_id[2:0]].done       = 1'b1;
        entries_d[bus.cdb_id[2:0]].value      = bus.cdb_value;
        entries_d[bus.cdb_id[2:0]].mispredict = bus.cdb_mispredict;
        entries_d[bus.cdb_id[2:0]].target     = bus.cdb_target;
      end else begin
        entries_d[bus.cdb_id[2:0]] = entries_q[bus.cdb_id[2:0]];
      end
      if (commit_s) begin
        entries_d[head_q].valid = 1'b0;
        head_d                  = head_q + 3'd1;
      end else begin
        head_d = head_q;
      end
      if (alloc_fire_s) begin
        entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                              dest: bus.alloc_dest, value: 16'h0000,
                              target: 16'h0000};
        tail_d            = tail_q + 3'd1;
      end else begin
        tail_d = tail_q;
      end
      count_d = count_q + {3'd0, alloc_fire_s} - {3'd0, commit_s};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= 3'd0;
      tail_q  <= 3'd0;
      count_q <= 4'd0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Output drive; retag owns the tag port over dispatch.
  always_comb begin
    bus.alloc_ready   = alloc_ready_s;
    bus.alloc_id      = reset ? 4'd0 : {1'b0, tail_q};
    bus.rf_load_value = value_write_s;
    bus.rf_value      = value_write_s ? head_e.value : 16'h0000;
    bus.rf_dest_value = value_write_s ? head_e.dest : 4'd0;
    bus.flush         = flush_s;
    bus.pc_load       = mispredict_commit_s;
    bus.pc_target     = mispredict_commit_s ? head_e.target : 16'h0000;
    bus.count         = reset ? 4'd0 : count_q;
    if (retag_hit_s) begin
      bus.rf_load_rob = 1'b1;
      bus.rf_rob_in   = retag_id_s;
      bus.rf_dest_rob = head_e.dest;
    end else if (alloc_fire_s) begin
      bus.rf_load_rob = 1'b1;
      bus.rf_rob_in   = {1'b0, tail_q};
      bus.rf_dest_rob = bus.alloc_dest;
    end else begin
      bus.rf_load_rob = 1'b0;
      bus.rf_rob_in   = 4'd0;
      bus.rf_dest_rob = 4'd0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Directed self-checking bench for reorder_buffer. Inputs change #1 after the
// rising edge; combinational outputs are sampled after settling, mid-cycle.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_req       = 1'b0;
    bus.alloc_dest      = 4'd0;
    bus.alloc_is_branch = 1'b0;
    bus.cdb_valid       = 1'b0;
    bus.cdb_id          = 4'd0;
    bus.cdb_value       = 16'h0000;
    bus.cdb_mispredict  = 1'b0;
    bus.cdb_target      = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic alloc(input logic [3:0] dest, input logic br);
    bus.alloc_req       = 1'b1;
    bus.alloc_dest      = dest;
    bus.alloc_is_branch = br;
    tick();
    bus.alloc_req       = 1'b0;
    bus.alloc_is_branch = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] id, input logic [15:0] val,
                     input logic mp, input logic [15:0] tgt);
    bus.cdb_valid      = 1'b1;
    bus.cdb_id         = id;
    bus.cdb_value      = val;
    bus.cdb_mispredict = mp;
    bus.cdb_target     = tgt;
    tick();
    bus.cdb_valid      = 1'b0;
    bus.cdb_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL reset_flush got %0b exp 1", bus.flush); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL reset_alloc_ready got %0b exp 0", bus.alloc_ready); end
    checks++; if ({bus.rf_load_value, bus.rf_load_rob, bus.pc_load} !== 3'b000) begin errors++; $display("FAIL reset_loads got %b exp 000", {bus.rf_load_value, bus.rf_load_rob, bus.pc_load}); end
    reset = 1'b0;
    tick();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL idle_flush got %0b exp 0", bus.flush); end
    checks++; if (bus.alloc_ready !== 1'b1 || bus.alloc_id !== 4'd0) begin errors++; $display("FAIL idle_alloc got ready %0b id %0d exp 1/0", bus.alloc_ready, bus.alloc_id); end
  endtask

  task automatic test_basic_commit();
    do_reset();
    bus.alloc_req  = 1'b1;
    bus.alloc_dest = 4'd1;
    #1;
    checks++; if (bus.rf_load_rob !== 1'b1 || bus.rf_rob_in !== 4'd0 || bus.rf_dest_rob !== 4'd1) begin errors++; $display("FAIL alloc_tag got %0b/%0d/%0d exp 1/0/1", bus.rf_load_rob, bus.rf_rob_in, bus.rf_dest_rob); end
    tick();
    bus.alloc_req = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", bus.count); end
    cdb(4'd0, 16'h1234, 1'b0, 16'h0000);
    checks++; if (bus.rf_load_value !== 1'b1 || bus.rf_dest_value !== 4'd1 || bus.rf_value !== 16'h1234) begin errors++; $display("FAIL basic_commit got %0b/%0d/%h exp 1/1/1234", bus.rf_load_value, bus.rf_dest_value, bus.rf_value); end
    tick();
    checks++; if (bus.count !== 4'd0 || bus.rf_load_value !== 1'b0) begin errors++; $display("FAIL basic_after got count %0d load %0b exp 0/0", bus.count, bus.rf_load_value); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) alloc(4'(i), 1'b0);
    checks++; if (bus.count !== 4'd8 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_state got count %0d ready %0b exp 8/0", bus.count, bus.alloc_ready); end
    cdb(4'd0, 16'h0077, 1'b0, 16'h0000);
    bus.alloc_req  = 1'b1;
    bus.alloc_dest = 4'd3;
    #1;
    checks++; if (bus.alloc_ready !== 1'b0 || bus.rf_load_rob !== 1'b0) begin errors++; $display("FAIL full_nobypass got ready %0b tag %0b exp 0/0", bus.alloc_ready, bus.rf_load_rob); end
    checks++; if (bus.rf_load_value !== 1'b1 || bus.rf_dest_value !== 4'd0 || bus.rf_value !== 16'h0077) begin errors++; $display("FAIL full_commit got %0b/%0d/%h exp 1/0/0077", bus.rf_load_value, bus.rf_dest_value, bus.rf_value); end
    tick();
    bus.alloc_req = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd7 || bus.alloc_ready !== 1'b1 || bus.alloc_id !== 4'd0) begin errors++; $display("FAIL full_after got count %0d ready %0b id %0d exp 7/1/0", bus.count, bus.alloc_ready, bus.alloc_id); end
  endtask

  task automatic test_retag();
    do_reset();
    alloc(4'd2, 1'b0);
    alloc(4'd2, 1'b0);
    cdb(4'd0, 16'h0055, 1'b0, 16'h0000);
    bus.alloc_req  = 1'b1;
    bus.alloc_dest = 4'd5;
    #1;
    checks++; if (bus.rf_load_value !== 1'b1 || bus.rf_dest_value !== 4'd2 || bus.rf_value !== 16'h0055) begin errors++; $display("FAIL retag_value got %0b/%0d/%h exp 1/2/0055", bus.rf_load_value, bus.rf_dest_value, bus.rf_value); end
    checks++; if (bus.rf_load_rob !== 1'b1 || bus.rf_rob_in !== 4'd1 || bus.rf_dest_rob !== 4'd2) begin errors++; $display("FAIL retag_tag got %0b/%0d/%0d exp 1/1/2", bus.rf_load_rob, bus.rf_rob_in, bus.rf_dest_rob); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL retag_stall got %0b exp 0", bus.alloc_ready); end
    tick();
    bus.alloc_req = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd1 || bus.alloc_id !== 4'd2) begin errors++; $display("FAIL retag_after got count %0d id %0d exp 1/2", bus.count, bus.alloc_id); end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(4'd1, 1'b0);
    alloc(4'd3, 1'b0);
    alloc(REGISTER_PC, 1'b1);
    alloc(4'd4, 1'b0);
    alloc(4'd5, 1'b0);
    cdb(4'd2, 16'h0000, 1'b1, 16'h0040);
    cdb(4'd0, 16'h0011, 1'b0, 16'h0000);
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = 4'd1;
    bus.cdb_value = 16'h0022;
    #1;
    checks++; if (bus.rf_dest_value !== 4'd1 || bus.rf_value !== 16'h0011 || bus.flush !== 1'b0) begin errors++; $display("FAIL mp_commit0 got %0d/%h flush %0b exp 1/0011/0", bus.rf_dest_value, bus.rf_value, bus.flush); end
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    checks++; if (bus.rf_dest_value !== 4'd3 || bus.rf_value !== 16'h0022 || bus.count !== 4'd4) begin errors++; $display("FAIL mp_commit1 got %0d/%h count %0d exp 3/0022/4", bus.rf_dest_value, bus.rf_value, bus.count); end
    tick();
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = 4'd3;
    bus.cdb_value = 16'h0033;
    #1;
    checks++; if (bus.flush !== 1'b1 || bus.pc_load !== 1'b1 || bus.pc_target !== 16'h0040) begin errors++; $display("FAIL mp_flush got %0b/%0b/%h exp 1/1/0040", bus.flush, bus.pc_load, bus.pc_target); end
    checks++; if (bus.rf_load_value !== 1'b0 || bus.alloc_ready !== 1'b0 || bus.rf_load_rob !== 1'b0) begin errors++; $display("FAIL mp_quiet got %0b/%0b/%0b exp 0/0/0", bus.rf_load_value, bus.alloc_ready, bus.rf_load_rob); end
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.alloc_id !== 4'd0 || bus.flush !== 1'b0 || bus.pc_load !== 1'b0) begin errors++; $display("FAIL mp_after got count %0d id %0d flush %0b pc %0b exp 0/0/0/0", bus.count, bus.alloc_id, bus.flush, bus.pc_load); end
    tick();
    checks++; if (bus.rf_load_value !== 1'b0 || bus.count !== 4'd0) begin errors++; $display("FAIL mp_nocommit got load %0b count %0d exp 0/0", bus.rf_load_value, bus.count); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc(4'd1, 1'b0);
    alloc(4'd2, 1'b0);
    cdb(4'd1, 16'h000b, 1'b0, 16'h0000);
    checks++; if (bus.rf_load_value !== 1'b0) begin errors++; $display("FAIL ooo_wait got %0b exp 0", bus.rf_load_value); end
    cdb(4'd0, 16'h000a, 1'b0, 16'h0000);
    checks++; if (bus.rf_dest_value !== 4'd1 || bus.rf_value !== 16'h000a) begin errors++; $display("FAIL ooo_first got %0d/%h exp 1/000a", bus.rf_dest_value, bus.rf_value); end
    tick();
    checks++; if (bus.rf_load_value !== 1'b1 || bus.rf_dest_value !== 4'd2 || bus.rf_value !== 16'h000b) begin errors++; $display("FAIL ooo_second got %0b/%0d/%h exp 1/2/000b", bus.rf_load_value, bus.rf_dest_value, bus.rf_value); end
    tick();
    checks++; if (bus.rf_load_value !== 1'b0 || bus.count !== 4'd0) begin errors++; $display("FAIL ooo_done got %0b count %0d exp 0/0", bus.rf_load_value, bus.count); end
  endtask

  task automatic test_wrap();
    logic [3:0]  exp_id;
    logic [15:0] exp_val;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      exp_id  = 4'(i % 8);
      exp_val = 16'(16'h0100 + i);
      checks++; if (bus.alloc_id !== exp_id) begin errors++; $display("FAIL wrap_id iter %0d got %0d exp %0d", i, bus.alloc_id, exp_id); end
      alloc(4'(1 + (i % 7)), 1'b0);
      cdb(exp_id, exp_val, 1'b0, 16'h0000);
      checks++; if (bus.rf_load_value !== 1'b1 || bus.rf_value !== exp_val) begin errors++; $display("FAIL wrap_commit iter %0d got %0b/%h exp 1/%h", i, bus.rf_load_value, bus.rf_value, exp_val); end
      tick();
    end
    checks++; if (bus.count !== 4'd0 || bus.alloc_id !== 4'd4) begin errors++; $display("FAIL wrap_end got count %0d id %0d exp 0/4", bus.count, bus.alloc_id); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(4'(i + 1), 1'b0);
    cdb(4'd0, 16'h0099, 1'b0, 16'h0000);
    reset = 1'b1;
    #1;
    checks++; if (bus.flush !== 1'b1 || bus.count !== 4'd0 || bus.rf_load_value !== 1'b0) begin errors++; $display("FAIL rst_mid got flush %0b count %0d load %0b exp 1/0/0", bus.flush, bus.count, bus.rf_load_value); end
    tick();
    reset = 1'b0;
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = 4'd1;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.flush !== 1'b0 || bus.rf_load_value !== 1'b0) begin errors++; $display("FAIL rst_after got count %0d flush %0b load %0b exp 0/0/0", bus.count, bus.flush, bus.rf_load_value); end
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    checks++; if (bus.rf_load_value !== 1'b0 || bus.count !== 4'd0) begin errors++; $display("FAIL rst_nocommit got load %0b count %0d exp 0/0", bus.rf_load_value, bus.count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_commit();
    test_full();
    test_retag();
    test_mispredict();
    test_out_of_order();
    test_wrap();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
